// File: rtl/sdrd_deserializer.sv
// sdrd_deserializer
//
// Collects the SDRD serial bit stream from the CLE36 sequencer and turns it
// into bytes. A bit is sampled on each qualified bus read into the CLE
// window. Bits are assembled LSB first. Each completed byte is offered to
// the host side over a valid/ready handshake.
//
// A qualified bus write into the same window resynchronises the shifter.
// An inactivity timeout discards a partially collected byte. A byte that
// completes while the output register is still occupied is dropped, and
// the sticky overrun flag is set.
//
// Optional feature: define SDRD_CHK_EN to build a running XOR checksum of
// delivered bytes on chk. When it is undefined, chk is tied to 0.
//
// Parameters:
//   TIMEOUT     idle clocks after the last sample before a partial byte is
//               discarded (1..65535)
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   bus_stb     one-clock strobe per bus cycle
//   sser        serial select, active low
//   ba13, ba12  bus address bits
//   br_w        bus read (1) / write (0)
//   sdrd        serial data bit
//   dout        assembled byte
//   dout_valid  dout holds an undelivered byte
//   dout_ready  consumer accepts dout when valid and ready are both high
//   bitcnt      bits collected toward the current byte
//   overrun     sticky: a byte completed while the output was occupied
//   timeout     one-clock pulse when a partial byte is discarded
//   chk         running checksum (0 unless SDRD_CHK_EN)

module sdrd_deserializer #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_stb,
  input  logic       sser,
  input  logic       ba13,
  input  logic       ba12,
  input  logic       br_w,
  input  logic       sdrd,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [2:0] bitcnt,
  output logic       overrun,
  output logic       timeout,
  output logic [7:0] chk
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT);

  state_t      state;
  state_t      state_next;

  logic        win;
  logic        sample;
  logic        resync;

  // Only the seven oldest bits need storage. The eighth bit arrives with the
  // completing sample and goes straight into the output byte.
  logic [6:0]  shreg;
  logic [7:0]  byte_next;
  logic [15:0] idle_cnt;

  logic        complete;
  logic        tmo_hit;
  logic        cnt_run;
  logic        load_out;

  assign win       = ~sser & ~ba13 & ba12;
  assign sample    = bus_stb & win & br_w;
  assign resync    = bus_stb & win & ~br_w;
  assign byte_next = {sdrd, shreg};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Resync takes priority over everything else.
  // Sample and resync are exclusive because they depend on opposite
  // values of br_w.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (!resync && sample) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (resync || complete || tmo_hit) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // Control decode from the state. The timeout fires on the clock where the
  // idle count would reach TIMEOUT. A sample or resync on that same clock
  // suppresses it.
  always_comb begin
    cnt_run  = 1'b0;
    complete = 1'b0;
    tmo_hit  = 1'b0;
    load_out = 1'b0;
    cnt_run  = (state == COLLECT);
    complete = sample && (bitcnt == 3'd7);
    tmo_hit  = cnt_run && !sample && !resync &&
               (({1'b0, idle_cnt} + 17'd1) == TMO_LIMIT);
    load_out = complete && (!dout_valid || dout_ready);
  end

  // Shifter, bit counter and idle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      bitcnt   <= '0;
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= tmo_hit;
      if (resync) begin
        shreg    <= '0;
        bitcnt   <= '0;
        idle_cnt <= '0;
      end else if (sample) begin
        shreg    <= {sdrd, shreg[6:1]};
        bitcnt   <= bitcnt + 3'd1;
        idle_cnt <= '0;
      end else if (tmo_hit) begin
        shreg    <= '0;
        bitcnt   <= '0;
        idle_cnt <= '0;
      end else if (cnt_run) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

  // One-byte output register with overrun detection. Accept and new
  // completion on the same clock reload with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load_out) begin
        dout       <= byte_next;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end

      if (resync) begin
        overrun <= 1'b0;
      end else if (complete && !load_out) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef SDRD_CHK_EN
  // Running XOR of every byte loaded into the output register. Dropped
  // bytes are not included.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk <= '0;
    end else if (resync) begin
      chk <= '0;
    end else if (load_out) begin
      chk <= chk ^ byte_next;
    end
  end
`else
  assign chk = 8'h00;
`endif

endmodule

// File: doc/sdrd_deserializer.md
# sdrd_deserializer

Downstream consumer of the serial-data-read (SDRD) bit stream produced by the CLE36 sequencer. Samples the SDRD bit on each qualified bus read into the CLE window, assembles bits LSB-first into bytes, and hands completed bytes to the host-side logic over a valid/ready handshake. Also provides resynchronisation, inactivity timeout and overrun detection.

## Interface
- `TIMEOUT`, default 1023: idle clocks, counted from the last sample, after which a partial byte is discarded. Range 1..65535.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bus_stb`  in  1  one-clock strobe per bus cycle; address and control inputs valid while high.
- `sser`  in  1  serial-select, active low.
- `ba13`, `ba12`  in  1 each  bus address bits.
- `br_w`  in  1  bus read (1) / write (0).
- `sdrd`  in  1  serial data bit from the CLE36 sequencer.
- `dout`  out  8  assembled byte.
- `dout_valid`  out  1  `dout` holds an undelivered byte.
- `dout_ready`  in  1  consumer accepts `dout` on a clock where valid and ready are both high.
- `bitcnt`  out  3  bits collected toward the current byte.
- `overrun`  out  1  sticky; a byte completed while the output was still occupied.
- `timeout`  out  1  one-clock pulse when a partial byte is discarded.
- `chk`  out  8  running checksum (only with `SDRD_CHK_EN`; otherwise tied to 0).

## Operation
- Window: `win = ~sser & ~ba13 & ba12`. Sample: `bus_stb & win & br_w`. Resync: `bus_stb & win & ~br_w`.
- Shifter: `shreg[7:0]`, `bitcnt[2:0]`. On each sample, `shreg <= {sdrd, shreg[7:1]}` (first bit lands in `dout[0]`), and `bitcnt` increments.
- Completion: a sample taken with `bitcnt==7` completes a byte. `{sdrd, shreg[7:1]}` loads the output register and `bitcnt` wraps to 0.
- Output register holds one byte:
  - If `dout_valid` is 0, or is 1 with `dout_ready` 1 on the same clock, the new byte is loaded and `dout_valid` stays or goes to 1.
  - Otherwise the new byte is dropped, `dout` is unchanged, and `overrun` sets.
- Acceptance: `dout_valid & dout_ready` with no completion clears `dout_valid`.
- Resync clears `bitcnt`, `shreg`, `overrun` and the idle counter. It does not affect `dout`/`dout_valid`. If sample and resync would coincide, resync wins; they are mutually exclusive by `br_w`.
- State machine:
  - IDLE (`bitcnt==0`, idle counter stopped).
  - COLLECT (`bitcnt!=0`, idle counter runs).
  - Transitions:
    - IDLE to COLLECT on a sample.
    - COLLECT to IDLE on completion, resync, or timeout.
- Timeout: the idle counter is 16 bits. It clears on every sample and increments each clock in COLLECT. When it reaches `TIMEOUT`: `bitcnt<=0`, `shreg<=0`, `timeout` pulses for one clock, and the state returns to IDLE.
- Non-window bus cycles and clocks with `bus_stb` low do not change the shifter.

## Timing
- Reset values: `dout=0`, `dout_valid=0`, `bitcnt=0`, `overrun=0`, `timeout=0`, `chk=0`, state IDLE.
- Reset mid-byte discards partial data. A held byte is lost.
- Latency: `dout_valid` rises on the clock after the 8th sample strobe.
- Back-to-back samples on every clock are supported: 1 bit/clock, 1 byte per 8 clocks.
- Handshake: `dout` is stable while `dout_valid` is high until accepted. Accept plus new completion on the same clock gives zero bubble.
- Timeout pulse: asserted exactly `TIMEOUT` clocks after the last sample. A sample on that same clock wins and no timeout fires.

## Configuration
- `SDRD_CHK_EN` defined:
  - `chk` is an 8-bit XOR of every byte loaded into the output register. A dropped (overrun) byte is not included.
  - `chk` clears on reset and on resync.
- `SDRD_CHK_EN` undefined: no checksum logic; `chk` is constant 0.

## Test plan
- Reset, then 8 samples with `sdrd` = 1,0,1,1,0,0,1,0 -> `dout=0x4D`, `dout_valid=1` one clock after the 8th; `bitcnt=0`.
- Hold `dout_ready=0` and complete two bytes 0x4D then 0xFF -> `dout` stays 0x4D, `overrun=1`. Resync -> `overrun=0`, `dout_valid` still 1.
- `dout_ready=1` continuously; 16 samples on consecutive clocks -> two valid pulses, no overrun.
- 3 samples then idle, `TIMEOUT=10` -> `timeout` pulse 10 clocks after the 3rd sample, `bitcnt=0`. The next 8 samples form a clean byte.
- Samples with `sser=1`, `ba13=1` or `ba12=0` -> `bitcnt` unchanged. Resync after 5 bits -> `bitcnt=0`.
- With `SDRD_CHK_EN`, deliver 0x4D then 0xFF -> `chk=0xB2`. Resync -> `chk=0`.
